vec_normalizer: RTL and testbench
=================================

VEC_NORMALIZER -- requirements
Module: vec_normalizer

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the maximum elements per vector (power of two, 2..16).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1 / in_data  input  32  signed Q16.16 element / in_last  input  1  final element of vector.
REQ-005 in_ready  output  1  element accepted when in_valid && in_ready.
REQ-006 recip_req  output  1  one-cycle start pulse to downstream reciprocal unit valid_in.
REQ-007 recip_x  output  32  signed Q16.16 vector sum presented with recip_req.
REQ-008 recip_valid  input  1 / recip_y  input  32  reciprocal result from reciprocal unit (valid_out, y_out).
REQ-009 out_valid  output  1 / out_data  output  32  normalized Q16.16 element / out_last  output  1 / out_ready  input  1.
REQ-010 zero_err  output  1  one-cycle pulse, vector sum was zero.
REQ-011 len_err  output  1  one-cycle pulse, DEPTH elements received without in_last.

Function
REQ-012 FSM states: LOAD, REQ, WAIT, EMIT; reset state LOAD.
REQ-013 LOAD: in_ready=1; each accepted element written to buffer[cnt], cnt incremented, sum accumulated.
REQ-014 Sum SHALL be 32-bit signed saturating: clamp to 0x7FFFFFFF / 0x80000000, never wrap.
REQ-015 LOAD exits to REQ on the accepted element with in_last=1, or on the DEPTH-th accepted element; the latter without in_last SHALL pulse len_err on the following cycle, and a later in_last is treated as an ordinary element of the next vector.
REQ-016 REQ, final sum != 0: recip_req=1 and recip_x=sum for exactly one cycle, next state WAIT.
REQ-017 REQ, final sum == 0: no recip_req; latch recip=0, pulse zero_err, go to EMIT (all outputs 0x00000000).
REQ-018 recip_x SHALL hold the last issued sum until the next REQ; in_ready=0 in REQ, WAIT, EMIT.
REQ-019 WAIT: on recip_valid=1 latch recip_y, go to EMIT; no timeout; recip_valid in any other state SHALL be ignored.
REQ-020 EMIT: out_data = round(buffer[idx] * recip): 64-bit signed product, add 0x8000, take bits [47:16], saturate to 0x7FFFFFFF/0x80000000 when bits [63:47] are not all equal.
REQ-021 out_data is registered; out_valid, out_data, out_last held stable while out_valid && !out_ready.
REQ-022 idx advances only on out_valid && out_ready; first out_valid no later than 2 cycles after entering EMIT.
REQ-023 out_last=1 only with the element idx == cnt-1; its handshake clears cnt, sum, idx and returns to LOAD.
REQ-024 Output order SHALL equal input order; element count out SHALL equal count in.
REQ-025 Throughput in EMIT: one element per cycle while out_ready=1.

Reset
REQ-026 rst=1 at any clock edge SHALL force state LOAD, cnt=0, idx=0, sum=0, recip=0.
REQ-027 Reset output values: in_ready=0 during rst, 1 on first cycle after; recip_req=0, recip_x=0, out_valid=0, out_data=0, out_last=0, zero_err=0, len_err=0.
REQ-028 Reset mid-WAIT or mid-EMIT: pending vector discarded; a recip_valid arriving after reset SHALL be ignored; no out_valid until a new vector completes.
REQ-029 Buffer contents need not be reset.

Verification
REQ-030 Vector 0x00010000,0x00010000,0x00020000,0x00040000(last) -> recip_req with recip_x=0x00080000; model returns recip_y=0x00002000 after 6 cycles -> outputs 0x00002000,0x00002000,0x00004000,0x00008000, out_last on 4th.
REQ-031 Single element 0x00020000 with in_last -> recip_x=0x00020000; recip_y=0x00008000 -> one output 0x00010000 with out_last=1.
REQ-032 Vector 0x00000000,0x00000000(last) -> no recip_req, zero_err pulse, outputs 0x00000000,0x00000000.
REQ-033 8 elements of 0x00010000, in_last never set -> len_err pulse, recip_x=0x00080000, in_ready low until 8 outputs of 0x00002000 drained.
REQ-034 Backpressure: out_ready toggled 1,0,0,1,... during REQ-030 -> out_data stable while stalled, same 4 values in order.
REQ-035 Reset asserted 2 cycles into WAIT, recip_valid pulsed 4 cycles later -> no out_valid; next vector processes normally.

Source files
------------

// File: rtl/vec_normalizer.sv
// vec_normalizer: buffers a Q16.16 vector, asks a reciprocal unit for 1/sum and
// streams each element scaled by that reciprocal, in arrival order.
module vec_normalizer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        recip_req,
  output logic [31:0] recip_x,
  input  logic        recip_valid,
  input  logic [31:0] recip_y,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        zero_err,
  output logic        len_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef enum logic [1:0] {LOAD, REQ, WAIT, EMIT} state_t;
  state_t state, state_d;
  logic [31:0] mem [DEPTH];
  logic [CW-1:0] cnt, idx;
  logic [31:0] sum, sum_d, recip, prod_sat;
  logic [32:0] sum_w;
  logic signed [63:0] elem_w, recip_w;
  logic [63:0] prod;
  logic acc, full, fin, load, done;
  assign in_ready = state == LOAD && !rst;
  assign recip_req = state == REQ && sum != 0 && !rst;
  assign zero_err = state == REQ && sum == 0 && !rst;
  assign acc = in_valid && in_ready;
  assign full = cnt == CW'(DEPTH - 1);
  assign fin = acc && (in_last || full);
  assign sum_w = {in_data[31], in_data} + {sum[31], sum};
  assign sum_d = sum_w[32] != sum_w[31] ? {sum_w[32], {31{~sum_w[32]}}} : sum_w[31:0];
  assign elem_w = 64'($signed(mem[idx[CW-2:0]]));
  assign recip_w = 64'($signed(recip));
  assign prod = elem_w * recip_w + 64'sh8000;
  // bits [63:47] all equal means the rounded result fits in Q16.16
  assign prod_sat = (&prod[63:47] || ~|prod[63:47]) ? prod[47:16] : {prod[63], {31{~prod[63]}}};
  // the output register refills whenever it is empty or being consumed
  assign load = state == EMIT && (!out_valid || out_ready) && idx < cnt;
  assign done = out_valid && out_ready && out_last;
  always_comb begin
    state_d = state;
    if (fin) state_d = REQ;
    else if (state == REQ) state_d = sum != 0 ? WAIT : EMIT;
    else if (state == WAIT && recip_valid) state_d = EMIT;
    else if (state == EMIT && done) state_d = LOAD;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else state <= state_d;
  end
  always_ff @(posedge clk) if (acc) mem[cnt[CW-2:0]] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      sum <= '0;
      recip <= '0;
      recip_x <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      len_err <= 1'b0;
    end else begin
      len_err <= acc && full && !in_last;
      if (acc) begin
        cnt <= cnt + CW'(1);
        sum <= sum_d;
      end
      if (fin && sum_d != 0) recip_x <= sum_d;
      if (state == REQ && sum == 0) recip <= '0;
      if (state == WAIT && recip_valid) recip <= recip_y;
      if (load) begin
        out_valid <= 1'b1;
        out_data <= prod_sat;
        out_last <= idx == cnt - CW'(1);
        idx <= idx + CW'(1);
      end else if (out_valid && out_ready) out_valid <= 1'b0;
      if (done) begin
        cnt <= '0;
        idx <= '0;
        sum <= '0;
        out_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vec_normalizer.sv
// tb_vec_normalizer: directed and random vectors checked against a plain-arithmetic model.
module tb_vec_normalizer;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, recip_valid = 0, out_ready = 0;
  logic [31:0] in_data = 0, recip_y = 0;
  logic in_ready, recip_req, out_valid, out_last, zero_err, len_err;
  logic [31:0] recip_x, out_data;
  int cmps = 0, fails = 0;
  logic [31:0] vec[$];
  logic nolast = 0;
  logic [31:0] last_x = 0;

  always #5 clk = ~clk;

  vec_normalizer #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .recip_req(recip_req), .recip_x(recip_x),
    .recip_valid(recip_valid), .recip_y(recip_y), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .zero_err(zero_err), .len_err(len_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmps++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] sat(input longint v);
    return v > 64'sd2147483647 ? 32'h7fffffff : v < -64'sd2147483648 ? 32'h80000000 : v[31:0];
  endfunction

  task automatic send_vec(input string nm);
    int k;
    foreach (vec[i]) begin
      in_valid = 1;
      in_data = vec[i];
      in_last = !nolast && i == vec.size() - 1;
      k = 0;
      while (!in_ready && k < 50) begin @(negedge clk); k++; end
      chk({nm, " in_ready"}, {31'b0, in_ready}, 1);
      @(negedge clk);
    end
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic run(input string nm, input int lat, input logic [31:0] y, input int rm);
    longint s = 0;
    logic [31:0] sum32, o, held = 0;
    logic [31:0] q[$];
    logic stall = 0, seen = 0;
    int n = 0, p = 0;
    foreach (vec[i]) s = longint'($signed(sat(s + longint'($signed(vec[i])))));
    sum32 = s[31:0];
    foreach (vec[i])
      q.push_back(sum32 == 0 ? 32'h0 :
                  sat((longint'($signed(vec[i])) * longint'($signed(y)) + 32768) >>> 16));
    send_vec(nm);
    chk({nm, " recip_req"}, {31'b0, recip_req}, {31'b0, sum32 != 0});
    chk({nm, " zero_err"}, {31'b0, zero_err}, {31'b0, sum32 == 0});
    chk({nm, " len_err"}, {31'b0, len_err}, {31'b0, nolast});
    if (sum32 != 0) last_x = sum32;
    chk({nm, " recip_x"}, recip_x, last_x);
    chk({nm, " in_ready low"}, {31'b0, in_ready}, 0);
    if (sum32 != 0) begin
      repeat (lat) begin
        @(negedge clk);
        chk({nm, " waiting"}, {29'b0, in_ready, out_valid, recip_req}, 0);
      end
      recip_valid = 1;
      recip_y = y;
      @(negedge clk);
      recip_valid = 0;
    end
    while (q.size() > 0 && n < 200) begin
      out_ready = rm == 0 ? 1'b1 : rm == 1 ? (p % 3 == 0) : 1'($urandom_range(0, 1));
      p++;
      if (stall) begin
        chk({nm, " stall valid"}, {31'b0, out_valid}, 1);
        chk({nm, " stall data"}, out_data, held);
      end
      if (rm == 0 && seen) chk({nm, " throughput"}, {31'b0, out_valid}, 1);
      if (out_valid) begin
        seen = 1;
        if (out_ready) begin
          o = q.pop_front();
          chk({nm, " out_data"}, out_data, o);
          chk({nm, " out_last"}, {31'b0, out_last}, {31'b0, q.size() == 0});
        end
        stall = !out_ready;
        held = out_data;
      end else stall = 0;
      chk({nm, " in_ready emit"}, {31'b0, in_ready}, 0);
      @(negedge clk);
      n++;
    end
    chk({nm, " drained"}, q.size(), 0);
    chk({nm, " back to load"}, {31'b0, in_ready}, 1);
    out_ready = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst in_ready", {31'b0, in_ready}, 0);
    chk("rst flags", {26'b0, recip_req, out_valid, out_last, zero_err, len_err, 1'b0}, 0);
    chk("rst recip_x", recip_x, 0);
    chk("rst out_data", out_data, 0);
    rst = 0;
    @(negedge clk);
    chk("post rst in_ready", {31'b0, in_ready}, 1);

    vec = '{32'h00010000, 32'h00010000, 32'h00020000, 32'h00040000};
    run("basic4", 6, 32'h00002000, 0);
    vec = '{32'h00020000};
    run("single", 3, 32'h00008000, 0);
    vec = '{32'h0, 32'h0};
    run("zero", 2, 32'h12345678, 0);
    vec = {};
    repeat (8) vec.push_back(32'h00010000);
    nolast = 1;
    run("len", 4, 32'h00002000, 0);
    nolast = 0;
    vec = '{32'h00010000, 32'h00010000, 32'h00020000, 32'h00040000};
    run("bkpr", 6, 32'h00002000, 1);
    vec = '{32'h7fff0000, 32'h00020000, 32'hfffe0000};
    run("satur", 2, 32'h00020000, 0);

    vec = '{32'h00010000, 32'h00030000};
    send_vec("rstwait");
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rstwait in_ready", {31'b0, in_ready}, 0);
    rst = 0;
    last_x = 0;
    repeat (3) @(negedge clk);
    chk("rstwait recip_x", recip_x, 0);
    recip_valid = 1;
    recip_y = 32'h00004000;
    @(negedge clk);
    recip_valid = 0;
    out_ready = 1;
    repeat (20) begin
      chk("rstwait no out", {31'b0, out_valid}, 0);
      @(negedge clk);
    end
    out_ready = 0;
    chk("rstwait in_ready back", {31'b0, in_ready}, 1);
    vec = '{32'h00010000, 32'h00030000};
    run("after rst", 5, 32'h00004000, 0);

    for (int t = 0; t < 12; t++) begin
      int len;
      len = $urandom_range(1, 8);
      nolast = len == 8 && $urandom_range(0, 1) == 1;
      vec = {};
      for (int i = 0; i < len; i++)
        vec.push_back($urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 32'h40000)) - 32'h20000);
      run("rand", $urandom_range(1, 8),
          $urandom_range(0, 1) == 1 ? $urandom : 32'($urandom_range(0, 32'h20000)), 2);
    end
    nolast = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end
endmodule
